// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues aligned byte/half/word requests over a req/gnt + rvalid bus,
// extends load data, stalls the pipeline while an access is outstanding, flags misalign and timeout.
module mem_access_unit #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk_i,
  input  logic        start_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] RS2Data_i,
  input  logic [2:0]  funct3_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic        RegWrite_i,
  output logic        RegWrite_o,
  output logic [31:0] DataMemReadData_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    off_q;
  logic [2:0]    funct3_q;

  logic        op, is_store, illegal, latch;
  logic [1:0]  size, off;
  logic        req, stall, mis, err, ld_done;
  logic [31:0] lane, load_ext;

  assign op       = MemRead_i | MemWrite_i;
  assign is_store = MemWrite_i & ~MemRead_i;  // a load wins when both are set
  assign size     = funct3_i[1:0];
  assign off      = ALUResult_i[1:0];
  assign illegal  = (size == 2'b11)
                  | ((size == 2'b01) & off[0])
                  | ((size == 2'b10) & (off != 2'b00))
                  | (is_store & funct3_i[2]);

  assign dmem_addr_o = {ALUResult_i[31:2], 2'b00};

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    dmem_be_o    = 4'b1111;
    dmem_wdata_o = RS2Data_i;
    case (size)
      2'b00: begin
        dmem_be_o    = 4'b0001 << off;
        dmem_wdata_o = {4{RS2Data_i[7:0]}};
      end
      2'b01: begin
        dmem_be_o    = 4'b0011 << off;
        dmem_wdata_o = {2{RS2Data_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign lane = dmem_rdata_i >> {off_q, 3'b000};

  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {24'b0, lane[7:0]};
      3'b101:  load_ext = {16'b0, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    latch   = 1'b0;
    req     = 1'b0;
    stall   = 1'b0;
    mis     = 1'b0;
    err     = 1'b0;
    ld_done = 1'b0;
    case (state)
      IDLE: begin
        if (op) begin
          if (illegal) begin
            mis = 1'b1;
          end else begin
            req   = 1'b1;
            latch = 1'b1;
            cnt_n = '0;
            if (!dmem_gnt_i) begin
              state_n = REQ;
              stall   = 1'b1;
            end else if (!is_store) begin
              state_n = WAIT;
              stall   = 1'b1;
            end
          end
        end
      end
      REQ: begin
        req = 1'b1;
        if (dmem_gnt_i) begin
          cnt_n = '0;
          if (is_store) begin
            state_n = IDLE;
          end else begin
            state_n = WAIT;
            stall   = 1'b1;
          end
        end else if (cnt == CNT_LAST) begin
          err     = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          stall = 1'b1;
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT: begin
        if (dmem_rvalid_i) begin
          ld_done = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          err     = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          stall = 1'b1;
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Reset gates every control output so an access in flight is abandoned immediately.
  assign dmem_req_o        = req & start_i;
  assign dmem_we_o         = req & is_store & start_i;
  assign stall_o           = stall & start_i;
  assign misalign_o        = mis & start_i;
  assign bus_err_o         = err & start_i;
  assign RegWrite_o        = RegWrite_i & start_i & ~mis & ~err;
  assign DataMemReadData_o = (ld_done & start_i) ? load_ext : 32'b0;

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state    <= IDLE;
      cnt      <= '0;
      off_q    <= 2'b00;
      funct3_q <= 3'b000;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (latch) begin
        off_q    <= off;
        funct3_q <= funct3_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized accesses against
// a transaction-level reference model (phase lengths, byte lanes and extension by arithmetic).
module tb_mem_access_unit;

  localparam int TIMEOUT_CYC = 16;

  logic        clk_i = 1'b0;
  logic        start_i;
  logic [31:0] ALUResult_i, RS2Data_i, dmem_rdata_i;
  logic [2:0]  funct3_i;
  logic        MemRead_i, MemWrite_i, RegWrite_i, dmem_gnt_i, dmem_rvalid_i;
  logic        RegWrite_o, stall_o, misalign_o, bus_err_o, dmem_req_o, dmem_we_o;
  logic [31:0] DataMemReadData_o, dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] last_data;

  mem_access_unit #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk_i(clk_i), .start_i(start_i), .ALUResult_i(ALUResult_i), .RS2Data_i(RS2Data_i),
    .funct3_i(funct3_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .RegWrite_i(RegWrite_i),
    .RegWrite_o(RegWrite_o), .DataMemReadData_o(DataMemReadData_o), .stall_o(stall_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".req"}, 32'(dmem_req_o), 32'd0);
    check({tag, ".we"}, 32'(dmem_we_o), 32'd0);
    check({tag, ".stall"}, 32'(stall_o), 32'd0);
    check({tag, ".mis"}, 32'(misalign_o), 32'd0);
    check({tag, ".err"}, 32'(bus_err_o), 32'd0);
    check({tag, ".regw"}, 32'(RegWrite_o), 32'd0);
    check({tag, ".data"}, DataMemReadData_o, 32'd0);
  endtask

  // gdel: cycles gnt stays low before it rises (>16 means never);
  // rdel: WAIT cycles before rvalid (>15 means never). Starts and ends just after a rising edge.
  task automatic run_txn(input string tag, input bit ld, input bit st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] rdata,
                         input int gdel, input int rdel);
    bit                is_load, is_store, illegal, req_to, wait_to, err, regw, last;
    int                bytes, n_req, n_wait, total;
    logic [3:0]        exp_be;
    logic [31:0]       exp_wd, exp_ld;
    longint unsigned   v;
    is_load    = ld;
    is_store   = st && !ld;
    regw       = 1'($urandom_range(0, 1));
    MemRead_i  = ld;
    MemWrite_i = st;
    funct3_i   = f3;
    ALUResult_i = addr;
    RS2Data_i  = rs2;
    RegWrite_i = regw;

    bytes   = 1 << f3[1:0];
    illegal = (f3[1:0] == 2'd3) || ((addr % bytes) != 0) || (is_store && f3[2]);
    exp_be  = (bytes == 4) ? 4'hF : 4'(((1 << bytes) - 1) << addr[1:0]);
    case (bytes)
      1:       exp_wd = 32'(rs2[7:0]) * 32'h0101_0101;
      2:       exp_wd = 32'(rs2[15:0]) * 32'h0001_0001;
      default: exp_wd = rs2;
    endcase
    v = longint'(rdata) >> (8 * addr[1:0]);
    if (bytes < 4) begin
      v = v % (64'd1 << (8 * bytes));
      if (!f3[2] && v >= (64'd1 << (8 * bytes - 1))) v = v - (64'd1 << (8 * bytes)) + (64'd1 << 32);
    end
    exp_ld = 32'(v);

    if (illegal) begin
      dmem_gnt_i    = 1'b1;
      dmem_rvalid_i = 1'b0;
      @(negedge clk_i);
      check({tag, ".mis"}, 32'(misalign_o), 32'd1);
      check({tag, ".req"}, 32'(dmem_req_o), 32'd0);
      check({tag, ".stall"}, 32'(stall_o), 32'd0);
      check({tag, ".regw"}, 32'(RegWrite_o), 32'd0);
      check({tag, ".err"}, 32'(bus_err_o), 32'd0);
      @(posedge clk_i); #1;
      return;
    end

    req_to  = gdel > TIMEOUT_CYC;
    n_req   = req_to ? TIMEOUT_CYC + 1 : gdel + 1;
    wait_to = is_load && !req_to && (rdel > TIMEOUT_CYC - 1);
    n_wait  = (is_load && !req_to) ? (wait_to ? TIMEOUT_CYC : rdel + 1) : 0;
    total   = n_req + n_wait;
    err     = req_to || wait_to;

    for (int c = 0; c < total; c++) begin
      last       = (c == total - 1);
      dmem_gnt_i = (c == gdel);
      if (c < n_req) begin
        dmem_rvalid_i = 1'($urandom_range(0, 1));  // must be ignored outside WAIT
        dmem_rdata_i  = $urandom;
      end else begin
        dmem_rvalid_i = (c == n_req + rdel);
        dmem_rdata_i  = dmem_rvalid_i ? rdata : $urandom;
      end
      @(negedge clk_i);
      check({tag, ".stall"}, 32'(stall_o), 32'(!last));
      check({tag, ".err"}, 32'(bus_err_o), 32'(err && last));
      check({tag, ".mis"}, 32'(misalign_o), 32'd0);
      check({tag, ".regw"}, 32'(RegWrite_o), 32'(regw && !(err && last)));
      check({tag, ".data"}, DataMemReadData_o, (is_load && !err && last) ? exp_ld : 32'd0);
      if (!(req_to && last)) check({tag, ".req"}, 32'(dmem_req_o), 32'(c < n_req));
      if (c < n_req) begin
        check({tag, ".we"}, 32'(dmem_we_o), 32'(is_store));
        check({tag, ".addr"}, dmem_addr_o, addr & 32'hFFFF_FFFC);
        check({tag, ".be"}, 32'(dmem_be_o), 32'(exp_be));
        if (is_store) check({tag, ".wdata"}, dmem_wdata_o, exp_wd);
      end
      if (last) last_data = DataMemReadData_o;
      @(posedge clk_i); #1;
    end
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
  endtask

  task automatic idle_cycle(input string tag);
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
    RegWrite_i = 1'b0;
    dmem_gnt_i = 1'b1;
    dmem_rvalid_i = 1'b1;
    @(negedge clk_i);
    check_quiet(tag);
    @(posedge clk_i); #1;
    dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b0;
  endtask

  initial begin
    logic [2:0] f3_tab [6];
    f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};

    // Reset: drive an access that would otherwise misalign and write back; all outputs stay low.
    start_i       = 1'b0;
    MemRead_i     = 1'b1;
    MemWrite_i    = 1'b0;
    RegWrite_i    = 1'b1;
    funct3_i      = 3'b001;
    ALUResult_i   = 32'h0000_0101;
    RS2Data_i     = 32'h0;
    dmem_gnt_i    = 1'b1;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_quiet("reset");
    MemRead_i     = 1'b0;
    RegWrite_i    = 1'b0;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b1;
    @(posedge clk_i); #1;

    // Byte store into the top lane.
    run_txn("sb", 0, 1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0, 0, 0);

    // Signed and unsigned byte loads from lane 2.
    run_txn("lb", 1, 0, 3'b000, 32'h0000_0102, 32'h0, 32'h0080_0000, 0, 0);
    check("lb.value", last_data, 32'hFFFF_FF80);
    run_txn("lbu", 1, 0, 3'b100, 32'h0000_0102, 32'h0, 32'h0080_0000, 0, 0);
    check("lbu.value", last_data, 32'h0000_0080);

    // Misaligned half and word loads.
    run_txn("lh_mis", 1, 0, 3'b001, 32'h0000_0101, 32'h0, 32'h0, 0, 0);
    run_txn("lw_mis", 1, 0, 3'b010, 32'h0000_0102, 32'h0, 32'h0, 0, 0);

    // Slow grant and slow response.
    run_txn("lw_slow", 1, 0, 3'b010, 32'h0000_0100, 32'h0, 32'h1234_5678, 3, 1);
    check("lw_slow.value", last_data, 32'h1234_5678);

    // Response timeout, then a store accepted on the very next cycle.
    run_txn("lw_to", 1, 0, 3'b010, 32'h0000_0200, 32'h0, 32'h0, 0, 99);
    run_txn("sw_after_to", 0, 1, 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 32'h0, 0, 0);

    // Grant timeout on a store, then a half load.
    run_txn("sh_to", 0, 1, 3'b001, 32'h0000_0302, 32'h0000_BEEF, 32'h0, 99, 0);
    run_txn("lh_after_to", 1, 0, 3'b001, 32'h0000_0302, 32'h0, 32'h8001_0000, 0, 0);
    check("lh_after_to.value", last_data, 32'hFFFF_8001);

    // Load and store both set behaves as a load; store with unsigned size is illegal.
    run_txn("both", 1, 1, 3'b101, 32'h0000_0402, 32'h0, 32'hABCD_0000, 1, 2);
    check("both.value", last_data, 32'h0000_ABCD);
    run_txn("sbu_ill", 0, 1, 3'b100, 32'h0000_0400, 32'h0, 32'h0, 0, 0);

    // Reset asserted while waiting for rvalid; a late rvalid must be ignored.
    MemRead_i   = 1'b1;
    MemWrite_i  = 1'b0;
    RegWrite_i  = 1'b1;
    funct3_i    = 3'b010;
    ALUResult_i = 32'h0000_0500;
    dmem_gnt_i  = 1'b1;
    @(negedge clk_i);
    check("rst_mid.req", 32'(dmem_req_o), 32'd1);
    check("rst_mid.stall0", 32'(stall_o), 32'd1);
    @(posedge clk_i); #1;
    dmem_gnt_i = 1'b0;
    @(negedge clk_i);
    check("rst_mid.stall1", 32'(stall_o), 32'd1);
    start_i = 1'b0;
    #1;
    check_quiet("rst_mid.in_reset");
    MemRead_i  = 1'b0;
    RegWrite_i = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h5A5A_5A5A;
    @(negedge clk_i);
    check_quiet("rst_mid.late_rvalid");
    @(posedge clk_i); #1;
    dmem_rvalid_i = 1'b0;

    // Randomized accesses.
    for (int i = 0; i < 80; i++) begin
      bit          ld, st;
      logic [2:0]  f3;
      logic [31:0] addr;
      int          bytes;
      ld   = 1'($urandom_range(0, 1));
      st   = ld ? ($urandom_range(0, 3) == 0) : 1'b1;
      f3   = f3_tab[$urandom_range(0, 5)];
      addr = $urandom;
      bytes = 1 << f3[1:0];
      if ($urandom_range(0, 3) != 0 && bytes <= 4) addr = addr & ~32'(bytes - 1);
      run_txn("rand", ld, st, f3, addr, $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) idle_cycle("rand_idle");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
